// File: rtl/demultiplexer_reg.sv
// 1-to-4 registered demultiplexer: routes `a` to the bus picked by `sel`, zeroes the rest,
// and flags the routed bus in a one-hot `valid` so a routed zero can be told apart from idle.
module demultiplexer_reg #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    output logic [3:0]       valid
);

    localparam int unsigned NUM_BUS = 4;

    logic [WIDTH-1:0]   w_d, w_q;
    logic [WIDTH-1:0]   x_d, x_q;
    logic [WIDTH-1:0]   y_d, y_q;
    logic [WIDTH-1:0]   z_d, z_q;
    logic [NUM_BUS-1:0] valid_d, valid_q;

    // Next-state steering: everything idles at zero unless enabled.
    always_comb begin
        w_d     = '0;
        x_d     = '0;
        y_d     = '0;
        z_d     = '0;
        valid_d = '0;
        if (en) begin
            unique case (sel)
                2'd0: w_d = a;
                2'd1: x_d = a;
                2'd2: y_d = a;
                2'd3: z_d = a;
                default: ;
            endcase
            valid_d = NUM_BUS'(1) << sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            valid_q <= '0;
        end else begin
            w_q     <= w_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            valid_q <= valid_d;
        end
    end

    assign w     = w_q;
    assign x     = x_q;
    assign y     = y_q;
    assign z     = z_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_demultiplexer_reg.sv
// Directed, table-driven bench for demultiplexer_reg (WIDTH=2 and WIDTH=8 instances).
module tb_demultiplexer_reg;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] sel;
    logic [1:0] a;
    logic [1:0] w, x, y, z;
    logic [3:0] valid;

    logic [1:0] sel8;
    logic [7:0] a8;
    logic [7:0] w8, x8, y8, z8;
    logic [3:0] valid8;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        logic       en;
        logic [1:0] sel;
        logic [1:0] a;
        logic [1:0] ew, ex, ey, ez;
        logic [3:0] ev;
    } vec_t;

    vec_t vecs[$];

    demultiplexer_reg #(.WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .a(a),
        .w(w), .x(x), .y(y), .z(z), .valid(valid)
    );

    demultiplexer_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel8), .a(a8),
        .w(w8), .x(x8), .y(y8), .z(z8), .valid(valid8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        assertions++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_bus(input string name, input logic [1:0] ew, input logic [1:0] ex,
                             input logic [1:0] ey, input logic [1:0] ez, input logic [3:0] ev);
        check(name, 64'({w, x, y, z, valid}), 64'({ew, ex, ey, ez, ev}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic e, input logic [1:0] s, input logic [1:0] d,
                                input logic [1:0] ew, input logic [1:0] ex, input logic [1:0] ey,
                                input logic [1:0] ez, input logic [3:0] ev);
        vec_t v;
        v.en = e; v.sel = s; v.a = d;
        v.ew = ew; v.ex = ex; v.ey = ey; v.ez = ez; v.ev = ev;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        sel   = 2'd2;
        a     = 2'd3;
        sel8  = 2'd2;
        a8    = 8'hA5;

        // Reset held across three edges with live inputs
        for (int i = 0; i < 3; i++) begin
            tick();
            check_bus("reset_hold", 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000);
        end
        check("reset_hold_w8", 64'({w8, x8, y8, z8, valid8}), 64'd0);
        rst_n = 1'b1;
        tick();
        check_bus("reset_release", 2'd0, 2'd0, 2'd3, 2'd0, 4'b0100);
        check("width8_y", 64'({w8, x8, y8, z8, valid8}), 64'({8'h00, 8'h00, 8'hA5, 8'h00, 4'b0100}));

        // Sweep
        vecs.push_back(mk(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0001));
        vecs.push_back(mk(1'b1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0010));
        vecs.push_back(mk(1'b1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 4'b0010));
        vecs.push_back(mk(1'b1, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 4'b0100));
        vecs.push_back(mk(1'b1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd0, 4'b0100));
        vecs.push_back(mk(1'b1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 4'b1000));
        vecs.push_back(mk(1'b1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd3, 4'b1000));
        // Exhaustive routing
        for (int s = 0; s < 4; s++) begin
            for (int d = 0; d < 4; d++) begin
                vecs.push_back(mk(1'b1, 2'(s), 2'(d),
                                  (s == 0) ? 2'(d) : 2'd0, (s == 1) ? 2'(d) : 2'd0,
                                  (s == 2) ? 2'(d) : 2'd0, (s == 3) ? 2'(d) : 2'd0,
                                  (s == 0) ? 4'b0001 : (s == 1) ? 4'b0010 :
                                  (s == 2) ? 4'b0100 : 4'b1000));
            end
        end
        // Enable / disable / re-enable
        vecs.push_back(mk(1'b1, 2'd1, 2'd3, 2'd0, 2'd3, 2'd0, 2'd0, 4'b0010));
        vecs.push_back(mk(1'b0, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000));
        vecs.push_back(mk(1'b0, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000));
        vecs.push_back(mk(1'b1, 2'd1, 2'd3, 2'd0, 2'd3, 2'd0, 2'd0, 4'b0010));

        foreach (vecs[i]) begin
            en  = vecs[i].en;
            sel = vecs[i].sel;
            a   = vecs[i].a;
            tick();
            check_bus($sformatf("vec%0d", i), vecs[i].ew, vecs[i].ex, vecs[i].ey, vecs[i].ez, vecs[i].ev);
        end

        // Async reset between edges while z is active
        en = 1'b1; sel = 2'd3; a = 2'd3;
        tick();
        check_bus("pre_async_z", 2'd0, 2'd0, 2'd0, 2'd3, 4'b1000);
        #2 rst_n = 1'b0;
        #1;
        check_bus("async_clear", 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000);
        sel = 2'd0; a = 2'd1;
        #1 rst_n = 1'b1;
        #1;
        check_bus("async_hold", 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000);
        tick();
        check_bus("async_recapture", 2'd1, 2'd0, 2'd0, 2'd0, 4'b0001);

        // Wider instance with other patterns
        sel8 = 2'd1; a8 = 8'h5A;
        tick();
        check("width8_x", 64'({w8, x8, y8, z8, valid8}), 64'({8'h00, 8'h5A, 8'h00, 8'h00, 4'b0010}));
        sel8 = 2'd3; a8 = 8'hFF;
        tick();
        check("width8_z", 64'({w8, x8, y8, z8, valid8}), 64'({8'h00, 8'h00, 8'h00, 8'hFF, 4'b1000}));

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/demultiplexer_reg.md
Name: demultiplexer_reg

Overview:
- 1-to-4 registered demultiplexer.
- Routes a WIDTH-bit data word `a` to one of four output buses (w, x, y, z), chosen by a 2-bit select.
- Non-selected buses are driven to zero.
- Used as a small datapath steering element. Outputs are registered on the system clock, with an asynchronous active-low reset.

Parameters:
- WIDTH, 2, bit width of data input `a` and of each output bus; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; tie high for plain demux operation.
- sel  input  2  output select: 0=w, 1=x, 2=y, 3=z.
- a  input  WIDTH  data word to route.
- w  output  WIDTH  registered output bus 0.
- x  output  WIDTH  registered output bus 1.
- y  output  WIDTH  registered output bus 2.
- z  output  WIDTH  registered output bus 3.
- valid  output  4  registered one-hot flag of the selected bus (bit0=w … bit3=z); all zero when idle.

Behaviour:
- Reset:
  - rst_n low asynchronously forces w=x=y=z=0 and valid=4'b0000, regardless of clk.
  - Outputs hold zero while rst_n is low.
  - The first capture occurs on the first rising clk edge after rst_n deasserts.
- Normal operation, on each rising clk edge with rst_n high and en=1:
  - Selected bus (per sel) <= a.
  - The other three buses <= 0.
  - valid <= one-hot(sel).
- Latency is exactly 1 clock from sel/a sampling to the outputs. There is no combinational path from inputs to outputs.
- Disabled (en=0 at a rising edge): all four buses <= 0 and valid <= 0.
- a = 0 with en=1: the selected bus is 0, but valid still flags the selected bus. This distinguishes "routed zero" from "idle".
- A sel change with a stable `a` moves the data to the new bus on the next edge. The old bus clears on that same edge, so there is never more than one nonzero bus.
- sel and a changing in the same cycle: both values are sampled together. There is no mixing between old and new values.
- Exactly one valid bit is set whenever en was 1 at the last edge.
- Data is passed through bit-exact; no arithmetic or width conversion.
- Reset asserted mid-stream clears everything immediately. Nothing captured before reset reappears after it.
- X/Z on sel while en=1 is illegal input. The verification bench must not drive it.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 with en=1, sel=2, a=3 for 3 clocks.
  - Required: w=x=y=z=0 and valid=0 throughout.
  - Stimulus: release rst_n.
  - Required: after the next edge, y=3 and valid=4'b0100.
- Sweep (en=1, WIDTH=2), checking one cycle after each change:
  - Start: sel=0, a=0 -> all outputs 0, valid=0001.
  - sel=1, a=0 -> all outputs 0, valid=0010.
  - a=1 -> x=1, others 0.
  - sel=2 -> y=1, x cleared.
  - a=2 -> y=2.
  - sel=3 -> z=2.
  - a=3 -> z=3, valid=1000.
- Exhaustive routing:
  - Stimulus: all 4 sel × all 4 a values.
  - Required: exactly the selected bus equals a; the other three are 0; valid is one-hot(sel); each result appears exactly 1 clock after being applied.
- Enable:
  - Stimulus: sel=1, a=3, en=1 for 1 clock.
  - Required: x=3.
  - Stimulus: then en=0.
  - Required: next edge gives all buses 0 and valid=0.
  - Stimulus: re-enable.
  - Required: x=3 again after 1 clock.
- Asynchronous reset mid-operation:
  - Stimulus: with z=3 active, pulse rst_n low between clock edges.
  - Required: outputs clear immediately, without waiting for clk.
  - Required: after release, the first edge re-captures the current sel/a.
- Parameter check:
  - Stimulus: instantiate WIDTH=8, sel=2, a=8'hA5.
  - Required: y=8'hA5, w=x=z=8'h00.
